// File: rtl/ttl_bank_pkg.sv
// Shared edge-mode encodings and the capture-decision helper for the TTL register bank.
// Pure combinational definitions; no state, no latency.
package ttl_bank_pkg;

    localparam logic [1:0] EDGE_RISE  = 2'd0;
    localparam logic [1:0] EDGE_FALL  = 2'd1;
    localparam logic [1:0] EDGE_BOTH  = 2'd2;
    localparam logic [1:0] EDGE_LEVEL = 2'd3;

    // Edge modes wait one armed cycle after reset so a strobe already high at reset cannot load.
    function automatic logic ttl_fire(
        input logic [1:0] mode,
        input logic       cen,
        input logic       last_cen,
        input logic       armed
    );
        logic rise;
        logic fall;
        rise = cen & ~last_cen;
        fall = ~cen & last_cen;
        case (mode)
            EDGE_RISE: return rise & armed;
            EDGE_FALL: return fall & armed;
            EDGE_BOTH: return (rise | fall) & armed;
            default:   return cen;
        endcase
    endfunction

endpackage

// File: rtl/ttl_dff_chan_sync.sv
// One register channel: strobe edge detect, arming, synchronous clear, STAGES-deep shift chain.
// New data reaches o_q after STAGES firing strobes; o_ld pulses on the edge that loads stage 0.
module ttl_dff_chan_sync
    import ttl_bank_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter int               STAGES    = 1,
    parameter int               EDGE_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cen,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_ld
);

    logic [WIDTH-1:0] r_stage [STAGES];
    logic             r_last_cen;
    logic             r_armed;
    logic             r_ld;
    logic             w_fire;

    assign w_fire = ttl_fire(2'(EDGE_MODE), i_cen, r_last_cen, r_armed);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= RESET_VAL;
            r_last_cen <= 1'b0;
            r_armed    <= 1'b0;
            r_ld       <= 1'b0;
        end else begin
            r_last_cen <= i_cen;
            r_armed    <= 1'b1;
            // Clear wins over a coincident strobe and forces zero, not the reset pattern.
            if (!i_clr_n) begin
                for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
                r_ld <= 1'b0;
            end else if (w_fire) begin
                r_stage[0] <= i_d;
                for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
                r_ld <= 1'b1;
            end else begin
                r_ld <= 1'b0;
            end
        end
    end

    assign o_q  = r_stage[STAGES-1];
    assign o_ld = r_ld;

endmodule

// File: rtl/ttl_dff_bank_sync.sv
// Bank of CHANNELS independent TTL-style D registers sharing one clock, with a global active-low OE.
// OE_n is a pure output mux; a disabled bank drives OE_VALUE per channel, as a pulled-up bus would.
module ttl_dff_bank_sync
    import ttl_bank_pkg::*;
#(
    parameter int               CHANNELS  = 2,
    parameter int               WIDTH     = 6,
    parameter int               STAGES    = 1,
    parameter int               EDGE_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] OE_VALUE  = '1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_cen,
    input  logic [CHANNELS-1:0]       i_clr_n,
    input  logic                      i_oe_n,
    input  logic [CHANNELS*WIDTH-1:0] i_d,
    output logic [CHANNELS*WIDTH-1:0] o_q,
    output logic [CHANNELS-1:0]       o_ld
);

    logic [WIDTH-1:0] w_q [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ttl_dff_chan_sync #(
            .WIDTH     (WIDTH),
            .STAGES    (STAGES),
            .EDGE_MODE (EDGE_MODE),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_cen   (i_cen[g]),
            .i_clr_n (i_clr_n[g]),
            .i_d     (i_d[g*WIDTH +: WIDTH]),
            .o_q     (w_q[g]),
            .o_ld    (o_ld[g])
        );

        assign o_q[g*WIDTH +: WIDTH] = i_oe_n ? OE_VALUE : w_q[g];
    end

endmodule

// File: tb/tb_ttl_dff_bank_sync.sv
// Directed bench for ttl_dff_bank_sync: four instances cover rise, fall/3-stage, both-edge and level modes.
// Inputs change 1 time unit after the rising clock edge; outputs are sampled at that same point.
module tb_ttl_dff_bank_sync;

    logic        clk;
    logic        rst;
    logic        oe_n;

    logic [1:0]  m0_cen, m0_clr, m0_ld;
    logic [11:0] m0_d, m0_q;
    logic [1:0]  m1_cen, m1_ld;
    logic [11:0] m1_d, m1_q;
    logic [1:0]  m2_cen, m2_ld;
    logic [11:0] m2_d, m2_q;
    logic [1:0]  m3_cen, m3_ld;
    logic [11:0] m3_d, m3_q;

    int n_checks = 0;
    int n_errors = 0;

    ttl_dff_bank_sync #(.CHANNELS(2), .WIDTH(6), .STAGES(1), .EDGE_MODE(0),
                        .RESET_VAL(6'h00), .OE_VALUE(6'h3F)) u_m0 (
        .i_clk(clk), .i_rst(rst), .i_cen(m0_cen), .i_clr_n(m0_clr), .i_oe_n(oe_n),
        .i_d(m0_d), .o_q(m0_q), .o_ld(m0_ld));

    ttl_dff_bank_sync #(.CHANNELS(2), .WIDTH(6), .STAGES(3), .EDGE_MODE(1),
                        .RESET_VAL(6'h15), .OE_VALUE(6'h3F)) u_m1 (
        .i_clk(clk), .i_rst(rst), .i_cen(m1_cen), .i_clr_n(2'b11), .i_oe_n(1'b0),
        .i_d(m1_d), .o_q(m1_q), .o_ld(m1_ld));

    ttl_dff_bank_sync #(.CHANNELS(2), .WIDTH(6), .STAGES(1), .EDGE_MODE(2),
                        .RESET_VAL(6'h00), .OE_VALUE(6'h3F)) u_m2 (
        .i_clk(clk), .i_rst(rst), .i_cen(m2_cen), .i_clr_n(2'b11), .i_oe_n(1'b0),
        .i_d(m2_d), .o_q(m2_q), .o_ld(m2_ld));

    ttl_dff_bank_sync #(.CHANNELS(2), .WIDTH(6), .STAGES(2), .EDGE_MODE(3),
                        .RESET_VAL(6'h00), .OE_VALUE(6'h3F)) u_m3 (
        .i_clk(clk), .i_rst(rst), .i_cen(m3_cen), .i_clr_n(2'b11), .i_oe_n(1'b0),
        .i_d(m3_d), .o_q(m3_q), .o_ld(m3_ld));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] m1_data [4];
    logic [5:0] m1_exp  [4];

    initial begin
        m1_data = '{6'h11, 6'h22, 6'h33, 6'h00};
        m1_exp  = '{6'h15, 6'h15, 6'h11, 6'h22};

        rst = 1'b1; oe_n = 1'b0;
        m0_cen = 2'b01; m0_clr = 2'b11; m0_d = {6'h00, 6'h2A};
        m1_cen = 2'b00; m1_d = '0;
        m2_cen = 2'b00; m2_d = '0;
        m3_cen = 2'b01; m3_d = '0;

        // Rising-edge channel, strobe already high across reset.
        tick();
        check("m0_rst_q",  16'(m0_q), 16'h000);
        check("m0_rst_ld", 16'(m0_ld), 16'h0);
        check("m1_rst_q",  16'(m1_q[5:0]), 16'h15);
        rst = 1'b0;
        tick();
        check("m0_noarm_q",  16'(m0_q[5:0]), 16'h00);
        check("m0_noarm_ld", 16'(m0_ld[0]), 16'h0);
        tick();
        check("m0_hold_q", 16'(m0_q[5:0]), 16'h00);
        m0_cen[0] = 1'b0; tick();
        m0_cen[0] = 1'b1; tick();
        check("m0_load_q",  16'(m0_q[5:0]), 16'h2A);
        check("m0_load_ld", 16'(m0_ld[0]), 16'h1);
        tick();
        check("m0_ldpulse_ld", 16'(m0_ld[0]), 16'h0);
        check("m0_ldpulse_q",  16'(m0_q[5:0]), 16'h2A);

        // Clear coincident with a rising strobe discards the load.
        m0_cen[0] = 1'b0; tick();
        m0_cen[0] = 1'b1; m0_clr[0] = 1'b0; m0_d[5:0] = 6'h3F; tick();
        check("clr_q",  16'(m0_q[5:0]), 16'h00);
        check("clr_ld", 16'(m0_ld[0]), 16'h0);
        m0_clr[0] = 1'b1; m0_cen[0] = 1'b0; tick();
        m0_cen[0] = 1'b1; tick();
        check("clr_after_q",  16'(m0_q[5:0]), 16'h3F);
        check("clr_after_ld", 16'(m0_ld[0]), 16'h1);

        // Output enable on channel 1 holding 0x05.
        m0_d[11:6] = 6'h05; m0_cen[1] = 1'b1; tick();
        check("ch1_load_q",  16'(m0_q[11:6]), 16'h05);
        check("ch1_load_ld", 16'(m0_ld), 16'h2);
        oe_n = 1'b1; #1;
        check("oe_ch1_q", 16'(m0_q[11:6]), 16'h3F);
        check("oe_ch0_q", 16'(m0_q[5:0]), 16'h3F);
        check("oe_ld",    16'(m0_ld[1]), 16'h1);
        oe_n = 1'b0; #1;
        check("oe_back_ch1_q", 16'(m0_q[11:6]), 16'h05);
        check("oe_back_ch0_q", 16'(m0_q[5:0]), 16'h3F);
        tick();
        check("oe_keep_ch1_q", 16'(m0_q[11:6]), 16'h05);

        // Falling-edge, three-stage cascade.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m1_cen[0] = 1'b1; tick();
            check($sformatf("m1_rise_ld%0d", i), 16'(m1_ld[0]), 16'h0);
            m1_cen[0] = 1'b0; m1_d[5:0] = m1_data[i]; tick();
            check($sformatf("m1_q%0d", i),  16'(m1_q[5:0]), 16'(m1_exp[i]));
            check($sformatf("m1_ld%0d", i), 16'(m1_ld[0]), 16'h1);
        end

        // Both-edge toggling strobe alongside a level-mode channel held high.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            m2_cen[0] = k[0];
            m2_d[5:0] = 6'(k);
            m3_d[5:0] = 6'(k);
            tick();
            check($sformatf("m2_q%0d", k),  16'(m2_q[5:0]), (k >= 2) ? 16'(k) : 16'h0);
            check($sformatf("m2_ld%0d", k), 16'(m2_ld[0]), (k >= 2) ? 16'h1 : 16'h0);
            check($sformatf("m3_q%0d", k),  16'(m3_q[5:0]), (k >= 2) ? 16'(k - 1) : 16'h0);
            check($sformatf("m3_ld%0d", k), 16'(m3_ld[0]), 16'h1);
        end

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        check("arst_m2_q",  16'(m2_q[5:0]), 16'h00);
        check("arst_m2_ld", 16'(m2_ld[0]), 16'h0);
        check("arst_m3_q",  16'(m3_q[5:0]), 16'h00);
        check("arst_m3_ld", 16'(m3_ld[0]), 16'h0);
        check("arst_m1_q",  16'(m1_q[5:0]), 16'h15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ttl_dff_bank_sync.md
Name: ttl_dff_bank_sync

Overview:
- Parametrised, clock-synchronous model of cascaded TTL D-register banks (74174/74175/74374 family) for the arcade core.
- CHANNELS independent registers, each WIDTH bits wide and STAGES deep, all on the single system clock.
- Each channel captures on a detected edge (or level) of its own enable strobe, with per-channel synchronous clear.
- Adds a global output-enable with a parked value and a per-channel load strobe.

Parameters:
- CHANNELS, 2: number of independent register channels.
- WIDTH, 6: data bits per channel.
- STAGES, 1: cascade depth per channel; Q is the last stage.
- EDGE_MODE, 0: 0 = rising edge of Cen, 1 = falling, 2 = both, 3 = level-high.
- RESET_VAL, 0: reset value of every stage bit; WIDTH bits, replicated across stages.
- OE_VALUE, all-ones: value driven on Q while OE_n = 1; WIDTH bits, replicated per channel; emulates a pulled-up bus.

Ports:
- Clk  in  1  system clock, all state on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Cen  in  CHANNELS  per-channel enable strobe; bit c belongs to channel c.
- Clr_n  in  CHANNELS  per-channel synchronous clear, active-low.
- OE_n  in  1  output enable, active-low, combinational on Q.
- D  in  CHANNELS*WIDTH  data; channel c uses bits [c*WIDTH +: WIDTH].
- Q  out  CHANNELS*WIDTH  last-stage data per channel, or OE_VALUE.
- Ld  out  CHANNELS  one-cycle pulse, high in the cycle in which the new capture is visible.

Behaviour:
- Reset asserted, at any time including mid-capture: all stages = RESET_VAL, Ld = 0, last_cen = 0, armed = 0 for every channel. Q = RESET_VAL if OE_n = 0, else OE_VALUE.
- Per channel, every Clk edge with Reset low:
  - last_cen <= Cen[c].
  - armed <= 1.
- Edge detect:
  - rise = Cen & ~last_cen; fall = ~Cen & last_cen.
  - fire = rise (mode 0), fall (mode 1), rise | fall (mode 2), Cen (mode 3).
  - In modes 0–2, fire is additionally gated by armed. The first cycle after reset never captures, so a strobe level already present at reset cannot cause a spurious load.
  - Mode 3 ignores armed.
- Priority per channel, highest first:
  - Clr_n = 0: all stages <= 0 (not RESET_VAL), Ld <= 0. A coincident fire is discarded; last_cen and armed still update.
  - fire = 1: stage0 <= D slice; stage k <= stage k-1 for k = 1..STAGES-1 (shift on the same strobe); Ld <= 1.
  - Otherwise: hold, Ld <= 0.
- Latency:
  - D sampled on the edge where fire is true appears on Q after 1 Clk edge when STAGES = 1.
  - In general, data reaches Q after STAGES firing events.
  - Ld rises at the same edge that updates stage0.
- Mode 3 with Cen held high: capture and shift every cycle; Ld held high continuously.
- OE_n: combinational mux only; it never affects stored state or Ld.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Cen toggling every cycle in mode 2: fires every cycle after the arming cycle.

Decomposition:
- Package ttl_bank_pkg:
  - EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2, EDGE_LEVEL = 3.
  - Function computing fire from (mode, cen, last_cen, armed).
- Sub-module ttl_dff_chan_sync: one channel (edge detect, arming, clear, stage chain, Ld).
- Top-level ttl_dff_bank_sync: generate loop over CHANNELS plus the OE_n mux.

Test Plan:
- Reset with Cen[0] = 1 held, mode 0, WIDTH 6, STAGES 1:
  - Release reset with D = 0x2A: no capture, Q = 0x00, Ld = 0.
  - Drop then raise Cen: Q = 0x2A one edge after the rise, Ld pulses once.
- Mode 1, STAGES 3:
  - Three falling strobes with D = 0x11, 0x22, 0x33: Q reads RESET_VAL, RESET_VAL, 0x11.
  - A fourth strobe with D = 0x00: Q = 0x22.
- Clr_n = 0 on the same cycle as a rising strobe with D = 0x3F: Q = 0x00, Ld = 0. The next strobe with Clr_n = 1 loads normally.
- Mode 2 with Cen toggling every cycle and D incrementing from 1:
  - Q follows D with 1-cycle lag, starting from the second post-reset cycle.
  - Ld high every cycle from then on.
- OE_n = 1 with OE_VALUE = 0x3F while channel 1 holds 0x05: Q slice = 0x3F. Dropping OE_n: 0x05 immediately, no state change.
- Reset asserted asynchronously mid-stream between Clk edges: Q = RESET_VAL and Ld = 0 before the next Clk edge.
